// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with EX-stage operand forwarding, stall hold and flush-to-bubble.
// Optional feature macro: IDEX_FWD_EN (forwarding muxes and stall-time WB refresh).
module id_ex_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_dst,
  input  logic [2:0]    id_alu_ctrl,
  input  logic          id_alusrc,
  input  logic          id_regwrite,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          em_regwrite,
  input  logic [RW-1:0] em_dst,
  input  logic [DW-1:0] em_data,
  input  logic          mw_regwrite,
  input  logic [RW-1:0] mw_dst,
  input  logic [DW-1:0] mw_data,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [2:0]    ex_alu_ctrl,
  output logic [DW-1:0] ex_alu_a,
  output logic [DW-1:0] ex_alu_b,
  output logic [DW-1:0] ex_store,
  output logic [RW-1:0] ex_dst,
  output logic          ex_regwrite,
  output logic          ex_memwrite,
  output logic          ex_memtoreg
);

  logic          valid_q, valid_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] rs_val_q, rs_val_d;
  logic [DW-1:0] rt_val_q, rt_val_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] dst_q, dst_d;
  logic [2:0]    alu_ctrl_q, alu_ctrl_d;
  logic          alusrc_q, alusrc_d;
  logic          regwrite_q, regwrite_d;
  logic          memwrite_q, memwrite_d;
  logic          memtoreg_q, memtoreg_d;

  logic [DW-1:0] rs_hold_s, rt_hold_s;
  logic [DW-1:0] rs_fwd_s, rt_fwd_s;

`ifdef IDEX_FWD_EN
  // EX/MEM has priority over MEM/WB; $0 is never forwarded.
  function automatic logic [DW-1:0] fwd_sel(
    input logic [RW-1:0] idx,
    input logic [DW-1:0] latched,
    input logic          em_we,
    input logic [RW-1:0] em_idx,
    input logic [DW-1:0] em_val,
    input logic          mw_we,
    input logic [RW-1:0] mw_idx,
    input logic [DW-1:0] mw_val
  );
    logic [DW-1:0] res;
    if (idx != {RW{1'b0}} && em_we && em_idx == idx) begin
      res = em_val;
    end else if (idx != {RW{1'b0}} && mw_we && mw_idx == idx) begin
      res = mw_val;
    end else begin
      res = latched;
    end
    return res;
  endfunction

  assign rs_fwd_s = fwd_sel(rs_q, rs_val_q, em_regwrite, em_dst, em_data,
                            mw_regwrite, mw_dst, mw_data);
  assign rt_fwd_s = fwd_sel(rt_q, rt_val_q, em_regwrite, em_dst, em_data,
                            mw_regwrite, mw_dst, mw_data);

  // A value retiring from WB while we are stalled would otherwise never reach this operand.
  assign rs_hold_s = (mw_regwrite && mw_dst != {RW{1'b0}} && mw_dst == rs_q) ? mw_data : rs_val_q;
  assign rt_hold_s = (mw_regwrite && mw_dst != {RW{1'b0}} && mw_dst == rt_q) ? mw_data : rt_val_q;
`else
  logic unused_fwd_s;

  assign rs_fwd_s     = rs_val_q;
  assign rt_fwd_s     = rt_val_q;
  assign rs_hold_s    = rs_val_q;
  assign rt_hold_s    = rt_val_q;
  assign unused_fwd_s = ^{em_regwrite, em_dst, em_data, mw_regwrite, mw_dst, mw_data, rs_q, rt_q};
`endif

  // Next-state selection: flush beats stall beats load.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs_val_d   = rs_val_q;
    rt_val_d   = rt_val_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    dst_d      = dst_q;
    alu_ctrl_d = alu_ctrl_q;
    alusrc_d   = alusrc_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      pc_d       = {DW{1'b0}};
      rs_val_d   = {DW{1'b0}};
      rt_val_d   = {DW{1'b0}};
      imm_d      = {DW{1'b0}};
      rs_d       = {RW{1'b0}};
      rt_d       = {RW{1'b0}};
      dst_d      = {RW{1'b0}};
      alu_ctrl_d = 3'b000;
      alusrc_d   = 1'b0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
    end else if (stall_i) begin
      rs_val_d = rs_hold_s;
      rt_val_d = rt_hold_s;
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs_val_d   = id_rs_val;
      rt_val_d   = id_rt_val;
      imm_d      = id_imm;
      rs_d       = id_rs;
      rt_d       = id_rt;
      dst_d      = id_dst;
      alu_ctrl_d = id_alu_ctrl;
      alusrc_d   = id_alusrc;
      regwrite_d = id_regwrite;
      memwrite_d = id_memwrite;
      memtoreg_d = id_memtoreg;
    end
  end

  // Pipeline state register; reset lands on a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      pc_q       <= {DW{1'b0}};
      rs_val_q   <= {DW{1'b0}};
      rt_val_q   <= {DW{1'b0}};
      imm_q      <= {DW{1'b0}};
      rs_q       <= {RW{1'b0}};
      rt_q       <= {RW{1'b0}};
      dst_q      <= {RW{1'b0}};
      alu_ctrl_q <= 3'b000;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dst_q      <= dst_d;
      alu_ctrl_q <= alu_ctrl_d;
      alusrc_q   <= alusrc_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_alu_ctrl = alu_ctrl_q;
  assign ex_alu_a    = rs_fwd_s;
  assign ex_alu_b    = alusrc_q ? imm_q : rt_fwd_s;
  assign ex_store    = rt_fwd_s;
  assign ex_dst      = dst_q;
  assign ex_regwrite = valid_q & regwrite_q;
  assign ex_memwrite = valid_q & memwrite_q;
  assign ex_memtoreg = valid_q & memtoreg_q;

endmodule
